// File: rtl/soml_mimo_detector.sv
// soml_mimo_detector: 4Tx/4Rx SM-Alamouti 16-QAM SOML detector (16 candidates).
// Ports: clk, rst (async low), start, H/Y beat streams in, decided symbols,
// winning index and 12 detected bits out. SOML_ROUND_EN: round-half-up rescale.
module soml_mimo_detector #(
  parameter int Q = 22,
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                H_in_valid,
  input  logic signed [N-1:0] H_in_r,
  input  logic signed [N-1:0] H_in_i,
  input  logic                Y_in_valid,
  input  logic signed [N-1:0] Y_in_r,
  input  logic signed [N-1:0] Y_in_i,
  output logic                output_valid,
  output logic signed [N-1:0] s_I_1,
  output logic signed [N-1:0] s_Q_1,
  output logic signed [N-1:0] s_I_2,
  output logic signed [N-1:0] s_Q_2,
  output logic [4:0]          Smin_index,
  output logic [11:0]         signal_out_12bit
);

  localparam int EW = N + 1;
  localparam int AW = N + 8;
  localparam int MW = N + 16;
  localparam int PW = 2 * EW;

`ifdef SOML_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (Q - 1);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEARCH,
    S_DONE
  } state_t;

  function automatic logic signed [AW-1:0] mulq(
    input logic signed [EW-1:0] x,
    input logic signed [EW-1:0] y
  );
    logic signed [PW-1:0] p;
    p = (PW'(x) * PW'(y) + RND) >>> Q;
    return AW'(p);
  endfunction

  function automatic logic signed [AW-1:0] cre(
    input logic signed [EW-1:0] ar,
    input logic signed [EW-1:0] ai,
    input logic signed [EW-1:0] br,
    input logic signed [EW-1:0] bi
  );
    return mulq(ar, br) - mulq(ai, bi);
  endfunction

  function automatic logic signed [AW-1:0] cim(
    input logic signed [EW-1:0] ar,
    input logic signed [EW-1:0] ai,
    input logic signed [EW-1:0] br,
    input logic signed [EW-1:0] bi
  );
    return mulq(ar, bi) + mulq(ai, br);
  endfunction

  // Thresholds at 0 and +/-2g; one extra bit keeps 2g from wrapping.
  function automatic logic signed [2:0] slice(
    input logic signed [AW-1:0] x,
    input logic signed [AW-1:0] g
  );
    logic signed [AW:0] xe;
    logic signed [AW:0] g2;
    xe = (AW+1)'(x);
    g2 = (AW+1)'(g) <<< 1;
    if (xe < -g2)
      return -3'sd3;
    else if (xe[AW])
      return -3'sd1;
    else if (xe < g2)
      return 3'sd1;
    else
      return 3'sd3;
  endfunction

  function automatic logic [1:0] gray(input logic signed [2:0] l);
    case (l)
      -3'sd3:  return 2'b00;
      -3'sd1:  return 2'b01;
      3'sd1:   return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic signed [MW-1:0] lvm(input logic [2:0] l);
    return MW'($signed(l));
  endfunction

  function automatic logic signed [N-1:0] lvs(input logic [2:0] l);
    return N'($signed(l)) <<< Q;
  endfunction

  state_t               state_q, state_d;
  logic [4:0]           h_cnt_q, h_cnt_d;
  logic [3:0]           y_cnt_q, y_cnt_d;
  logic [3:0]           k_q, k_d;
  logic signed [N-1:0]  h_r_q [16];
  logic signed [N-1:0]  h_i_q [16];
  logic signed [N-1:0]  y_r_q [8];
  logic signed [N-1:0]  y_i_q [8];
  logic signed [N-1:0]  h_r_d [16];
  logic signed [N-1:0]  h_i_d [16];
  logic signed [N-1:0]  y_r_d [8];
  logic signed [N-1:0]  y_i_d [8];
  logic signed [MW-1:0] best_m_q, best_m_d;
  logic [3:0]           best_k_q, best_k_d;
  logic [11:0]          best_lv_q, best_lv_d;
  logic                 ov_q, ov_d;
  logic [4:0]           idx_q, idx_d;
  logic [11:0]          bits_q, bits_d;
  logic signed [N-1:0]  s1i_q, s1i_d;
  logic signed [N-1:0]  s1q_q, s1q_d;
  logic signed [N-1:0]  s2i_q, s2i_d;
  logic signed [N-1:0]  s2q_q, s2q_d;

  logic signed [AW-1:0] g_acc;
  logic signed [AW-1:0] z1r, z1i, z2r, z2i;
  logic signed [2:0]    l1i, l1q, l2i, l2q;
  logic [11:0]          cur_lv;
  logic signed [MW-1:0] m_cur;

  // One full candidate per cycle: accumulate over the 4 Rx rows,
  // slice, and form the metric.
  always_comb begin : cand_eval
    logic signed [EW-1:0] ar, ai, hr, hi, br, bi;
    logic signed [EW-1:0] y1r, y1i, y2r, y2i;
    logic [1:0]           col_a, col_b;
    logic [3:0]           ia, ib;
    logic [2:0]           iy;
    logic signed [MW-1:0] en, cr;
    g_acc = '0;
    z1r = '0;
    z1i = '0;
    z2r = '0;
    z2i = '0;
    ar = '0;
    ai = '0;
    hr = '0;
    hi = '0;
    br = '0;
    bi = '0;
    y1r = '0;
    y1i = '0;
    y2r = '0;
    y2i = '0;
    col_a = k_q[1:0];
    col_b = k_q[1:0] + 2'd1;
    ia = '0;
    ib = '0;
    iy = '0;
    for (int i = 0; i < 4; i++) begin
      ia = {i[1:0], col_a};
      ib = {i[1:0], col_b};
      iy = {i[1:0], 1'b0};
      ar = EW'(h_r_q[ia]);
      ai = EW'(h_i_q[ia]);
      hr = EW'(h_r_q[ib]);
      hi = EW'(h_i_q[ib]);
      unique case (k_q[3:2])
        2'd0: begin br = hr;  bi = hi;  end
        2'd1: begin br = -hi; bi = hr;  end
        2'd2: begin br = -hr; bi = -hi; end
        default: begin br = hi; bi = -hr; end
      endcase
      y1r = EW'(y_r_q[iy]);
      y1i = EW'(y_i_q[iy]);
      y2r = EW'(y_r_q[iy + 3'd1]);
      y2i = EW'(y_i_q[iy + 3'd1]);
      g_acc = g_acc + mulq(ar, ar) + mulq(ai, ai)
                    + mulq(br, br) + mulq(bi, bi);
      z1r = z1r + cre(ar, -ai, y1r, y1i) + cre(br, bi, y2r, -y2i);
      z1i = z1i + cim(ar, -ai, y1r, y1i) + cim(br, bi, y2r, -y2i);
      z2r = z2r + cre(br, -bi, y1r, y1i) - cre(ar, ai, y2r, -y2i);
      z2i = z2i + cim(br, -bi, y1r, y1i) - cim(ar, ai, y2r, -y2i);
    end
    l1i = slice(z1r, g_acc);
    l1q = slice(z1i, g_acc);
    l2i = slice(z2r, g_acc);
    l2q = slice(z2i, g_acc);
    cur_lv = {l1i, l1q, l2i, l2q};
    en = lvm(l1i) * lvm(l1i) + lvm(l1q) * lvm(l1q)
       + lvm(l2i) * lvm(l2i) + lvm(l2q) * lvm(l2q);
    cr = MW'(z1r) * lvm(l1i) + MW'(z1i) * lvm(l1q)
       + MW'(z2r) * lvm(l2i) + MW'(z2i) * lvm(l2q);
    m_cur = MW'(g_acc) * en - (cr <<< 1);
  end

  always_comb begin : ctrl
    logic        take;
    logic [3:0]  f_k;
    logic [11:0] f_lv;
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    y_cnt_d = y_cnt_q;
    k_d = k_q;
    h_r_d = h_r_q;
    h_i_d = h_i_q;
    y_r_d = y_r_q;
    y_i_d = y_i_q;
    best_m_d = best_m_q;
    best_k_d = best_k_q;
    best_lv_d = best_lv_q;
    ov_d = ov_q;
    idx_d = idx_q;
    bits_d = bits_q;
    s1i_d = s1i_q;
    s1q_d = s1q_q;
    s2i_d = s2i_q;
    s2q_d = s2q_q;
    // Strict less-than keeps the lowest k on ties.
    take = (k_q == 4'd0) || (m_cur < best_m_q);
    f_k = take ? k_q : best_k_q;
    f_lv = take ? cur_lv : best_lv_q;
    if (start) begin
      state_d = S_LOAD;
      h_cnt_d = '0;
      y_cnt_d = '0;
      ov_d = 1'b0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (H_in_valid && h_cnt_q != 5'd16) begin
            h_r_d[h_cnt_q[3:0]] = H_in_r;
            h_i_d[h_cnt_q[3:0]] = H_in_i;
            h_cnt_d = h_cnt_q + 5'd1;
          end
          if (Y_in_valid && y_cnt_q != 4'd8) begin
            y_r_d[y_cnt_q[2:0]] = Y_in_r;
            y_i_d[y_cnt_q[2:0]] = Y_in_i;
            y_cnt_d = y_cnt_q + 4'd1;
          end
          if (h_cnt_q == 5'd16 && y_cnt_q == 4'd8) begin
            state_d = S_SEARCH;
            k_d = '0;
          end
        end
        S_SEARCH: begin
          if (take) begin
            best_m_d = m_cur;
            best_k_d = k_q;
            best_lv_d = cur_lv;
          end
          if (k_q == 4'hf) begin
            state_d = S_DONE;
            ov_d = 1'b1;
            idx_d = {1'b0, f_k};
            bits_d = {f_k, gray(f_lv[11:9]), gray(f_lv[8:6]),
                      gray(f_lv[5:3]), gray(f_lv[2:0])};
            s1i_d = lvs(f_lv[11:9]);
            s1q_d = lvs(f_lv[8:6]);
            s2i_d = lvs(f_lv[5:3]);
            s2q_d = lvs(f_lv[2:0]);
          end else begin
            k_d = k_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      h_cnt_q <= '0;
      y_cnt_q <= '0;
      k_q <= '0;
      for (int i = 0; i < 16; i++) begin
        h_r_q[i] <= '0;
        h_i_q[i] <= '0;
      end
      for (int i = 0; i < 8; i++) begin
        y_r_q[i] <= '0;
        y_i_q[i] <= '0;
      end
      best_m_q <= '0;
      best_k_q <= '0;
      best_lv_q <= '0;
      ov_q <= 1'b0;
      idx_q <= '0;
      bits_q <= '0;
      s1i_q <= '0;
      s1q_q <= '0;
      s2i_q <= '0;
      s2q_q <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      y_cnt_q <= y_cnt_d;
      k_q <= k_d;
      h_r_q <= h_r_d;
      h_i_q <= h_i_d;
      y_r_q <= y_r_d;
      y_i_q <= y_i_d;
      best_m_q <= best_m_d;
      best_k_q <= best_k_d;
      best_lv_q <= best_lv_d;
      ov_q <= ov_d;
      idx_q <= idx_d;
      bits_q <= bits_d;
      s1i_q <= s1i_d;
      s1q_q <= s1q_d;
      s2i_q <= s2i_d;
      s2q_q <= s2q_d;
    end
  end

  assign output_valid = ov_q;
  assign Smin_index = idx_q;
  assign signal_out_12bit = bits_q;
  assign s_I_1 = s1i_q;
  assign s_Q_1 = s1q_q;
  assign s_I_2 = s2i_q;
  assign s_Q_2 = s2q_q;

endmodule

// File: tb/tb_soml_mimo_detector.sv
// tb_soml_mimo_detector: directed plus randomized decodes of soml_mimo_detector
// against a longint reference model of the SOML search.
`timescale 1ns/1ps
module tb_soml_mimo_detector;
  localparam int Q = 22;
  localparam int N = 32;
  localparam longint ONE = longint'(1) <<< Q;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                H_in_valid = 1'b0;
  logic signed [N-1:0] H_in_r = '0;
  logic signed [N-1:0] H_in_i = '0;
  logic                Y_in_valid = 1'b0;
  logic signed [N-1:0] Y_in_r = '0;
  logic signed [N-1:0] Y_in_i = '0;
  logic                output_valid;
  logic signed [N-1:0] s_I_1, s_Q_1, s_I_2, s_Q_2;
  logic [4:0]          Smin_index;
  logic [11:0]         signal_out_12bit;

  soml_mimo_detector #(.Q(Q), .N(N)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .H_in_valid(H_in_valid),
    .H_in_r(H_in_r),
    .H_in_i(H_in_i),
    .Y_in_valid(Y_in_valid),
    .Y_in_r(Y_in_r),
    .Y_in_i(Y_in_i),
    .output_valid(output_valid),
    .s_I_1(s_I_1),
    .s_Q_1(s_Q_1),
    .s_I_2(s_I_2),
    .s_Q_2(s_Q_2),
    .Smin_index(Smin_index),
    .signal_out_12bit(signal_out_12bit)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  longint mh_r[16], mh_i[16], my_r[8], my_i[8];
  int gmap[4] = '{0, 1, 3, 2};
  int exp_idx, exp_bits;
  int exp_lv[4];

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint qm(input longint a, input longint b);
`ifdef SOML_ROUND_EN
    return (a * b + (longint'(1) <<< (Q - 1))) >>> Q;
`else
    return (a * b) >>> Q;
`endif
  endfunction

  function automatic void cmul(input longint ar, input longint ai,
                               input longint br, input longint bi,
                               output longint re, output longint im);
    re = qm(ar, br) - qm(ai, bi);
    im = qm(ar, bi) + qm(ai, br);
  endfunction

  function automatic int slc(input longint x, input longint g);
    if (x < -2 * g) return -3;
    if (x < 0) return -1;
    if (x < 2 * g) return 1;
    return 3;
  endfunction

  function automatic void column(input int row, input int col, input int rot,
                                 output longint cr, output longint ci);
    longint t;
    cr = mh_r[row * 4 + col];
    ci = mh_i[row * 4 + col];
    for (int n = 0; n < rot; n++) begin
      t = cr;
      cr = -ci;
      ci = t;
    end
  endfunction

  // Exhaustive candidate search straight from the detector equations.
  task automatic ref_decode();
    longint best_m, m, g, ar, ai, br, bi, pr, pi, qr, qi;
    longint z[4];
    int lv[4];
    best_m = 0;
    for (int k = 0; k < 16; k++) begin
      g = 0;
      for (int j = 0; j < 4; j++) z[j] = 0;
      for (int i = 0; i < 4; i++) begin
        column(i, k % 4, 0, ar, ai);
        column(i, (k + 1) % 4, k / 4, br, bi);
        g += qm(ar, ar) + qm(ai, ai) + qm(br, br) + qm(bi, bi);
        cmul(ar, -ai, my_r[2*i], my_i[2*i], pr, pi);
        cmul(br, bi, my_r[2*i+1], -my_i[2*i+1], qr, qi);
        z[0] += pr + qr;
        z[1] += pi + qi;
        cmul(br, -bi, my_r[2*i], my_i[2*i], pr, pi);
        cmul(ar, ai, my_r[2*i+1], -my_i[2*i+1], qr, qi);
        z[2] += pr - qr;
        z[3] += pi - qi;
      end
      m = 0;
      for (int j = 0; j < 4; j++) begin
        lv[j] = slc(z[j], g);
        m += g * lv[j] * lv[j] - 2 * z[j] * lv[j];
      end
      if (k == 0 || m < best_m) begin
        best_m = m;
        exp_idx = k;
        exp_bits = k << 8;
        for (int j = 0; j < 4; j++) begin
          exp_lv[j] = lv[j];
          exp_bits |= gmap[(lv[j] + 3) / 2] << (6 - 2 * j);
        end
      end
    end
  endtask

  function automatic longint rnd(input int amp);
    return longint'($urandom_range(0, 2 * amp)) - amp;
  endfunction

  // Y = H X for the Alamouti block of candidate k, plus optional noise.
  task automatic gen_y(input int k, input int s1i, input int s1q,
                       input int s2i, input int s2q, input int namp);
    longint ar, ai, br, bi;
    for (int i = 0; i < 4; i++) begin
      column(i, k % 4, 0, ar, ai);
      column(i, (k + 1) % 4, k / 4, br, bi);
      my_r[2*i] = ar*s1i - ai*s1q + br*s2i - bi*s2q + rnd(namp);
      my_i[2*i] = ar*s1q + ai*s1i + br*s2q + bi*s2i + rnd(namp);
      my_r[2*i+1] = -(ar*s2i + ai*s2q) + br*s1i + bi*s1q + rnd(namp);
      my_i[2*i+1] = -(ai*s2i - ar*s2q) + bi*s1i - br*s1q + rnd(namp);
    end
  endtask

  task automatic set_identity();
    for (int n = 0; n < 16; n++) begin
      mh_r[n] = (n / 4 == n % 4) ? ONE : 0;
      mh_i[n] = 0;
    end
  endtask

  task automatic set_basic();
    set_identity();
    for (int m = 0; m < 8; m++) begin
      my_r[m] = 0;
      my_i[m] = 0;
    end
    my_r[2] = 3 * ONE;  my_i[2] = ONE;
    my_r[3] = ONE;      my_i[3] = -3 * ONE;
    my_r[4] = -ONE;     my_i[4] = -3 * ONE;
    my_r[5] = 3 * ONE;  my_i[5] = -ONE;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ov_drop_on_start", output_valid, 0);
  endtask

  task automatic send(input bit gaps, input int h_lim);
    int hi, yi, c;
    bit saw;
    hi = 0;
    yi = 0;
    c = 0;
    saw = 0;
    while (hi < h_lim || yi < 8) begin
      @(posedge clk); #1;
      if (output_valid) saw = 1;
      H_in_valid = (hi < h_lim) && !(gaps && c >= 5 && c < 8);
      if (H_in_valid) begin
        H_in_r = N'(mh_r[hi]);
        H_in_i = N'(mh_i[hi]);
        hi++;
      end
      Y_in_valid = (yi < 8) && !(gaps && c >= 2 && c < 5);
      if (Y_in_valid) begin
        Y_in_r = N'(my_r[yi]);
        Y_in_i = N'(my_i[yi]);
        yi++;
      end
      c++;
    end
    @(posedge clk); #1;
    if (output_valid) saw = 1;
    H_in_valid = 1'b0;
    Y_in_valid = 1'b0;
    check("ov_low_during_load", saw, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!output_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ov_rise", output_valid, 1);
    check("latency_le_80", n <= 80, 1);
  endtask

  task automatic check_out(input int idx, input int bits, input int a,
                           input int b, input int c, input int d);
    check("smin_index", Smin_index, idx);
    check("bits12", signal_out_12bit, bits);
    check("s_I_1", s_I_1, a * ONE);
    check("s_Q_1", s_Q_1, b * ONE);
    check("s_I_2", s_I_2, c * ONE);
    check("s_Q_2", s_Q_2, d * ONE);
  endtask

  task automatic run(input bit gaps);
    pulse_start();
    send(gaps, 16);
    wait_done();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ov", output_valid, 0);
    check("rst_idx", Smin_index, 0);
    check("rst_bits", signal_out_12bit, 0);
    check("rst_s_I_1", s_I_1, 0);
    rst = 1'b1;

    set_basic();
    run(0);
    check_out(1, 12'b0001_1011_0100, 3, 1, -1, -3);
    repeat (5) @(posedge clk);
    #1;
    check("ov_hold", output_valid, 1);
    check("idx_hold", Smin_index, 1);

    run(1);
    check_out(1, 12'b0001_1011_0100, 3, 1, -1, -3);

    set_identity();
    gen_y(5, 1, 1, 1, 1, 0);
    run(0);
    check_out(5, 12'b0101_1111_1111, 1, 1, 1, 1);

    set_identity();
    for (int m = 0; m < 8; m++) begin
      my_r[m] = 0;
      my_i[m] = 0;
    end
    run(0);
    check_out(0, 12'b0000_1111_1111, 1, 1, 1, 1);

    for (int n = 0; n < 16; n++) begin
      mh_r[n] = rnd(int'(ONE));
      mh_i[n] = rnd(int'(ONE));
    end
    gen_y(9, 3, -1, 1, -3, 0);
    pulse_start();
    send(0, 16);
    repeat (6) @(posedge clk);
    #1;
    check("abort_ov_low", output_valid, 0);
    set_basic();
    run(0);
    check_out(1, 12'b0001_1011_0100, 3, 1, -1, -3);

    pulse_start();
    send(0, 5);
    rst = 1'b0;
    #1;
    check("rst_mid_ov", output_valid, 0);
    check("rst_mid_idx", Smin_index, 0);
    check("rst_mid_bits", signal_out_12bit, 0);
    check("rst_mid_s_I_1", s_I_1, 0);
    check("rst_mid_s_Q_2", s_Q_2, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run(0);
    check_out(1, 12'b0001_1011_0100, 3, 1, -1, -3);

    for (int t = 0; t < 24; t++) begin
      int k;
      int lv[4];
      for (int n = 0; n < 16; n++) begin
        mh_r[n] = rnd(int'(3 * ONE / 2));
        mh_i[n] = rnd(int'(3 * ONE / 2));
      end
      k = int'($urandom_range(0, 15));
      for (int j = 0; j < 4; j++) lv[j] = 2 * int'($urandom_range(0, 3)) - 3;
      gen_y(k, lv[0], lv[1], lv[2], lv[3], (t % 3 == 0) ? int'(ONE) : int'(ONE / 4));
      ref_decode();
      run(t[0]);
      check_out(exp_idx, exp_bits, exp_lv[0], exp_lv[1], exp_lv[2], exp_lv[3]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
